// File: rtl/histogram_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | histogram_accum: streaming per-bin histogram with pipelined read-modify-write
// | increment, clear sweep and read-and-clear valid/ready readout.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module histogram_accum #(
  parameter int BIN_WIDTH   = 8,
  parameter int COUNT_WIDTH = 32,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [BIN_WIDTH-1:0]   pix_bin,
  input  logic                   frame_end,
  input  logic                   clear_req,
  output logic                   in_ready,
  output logic                   pix_drop,
  output logic                   busy,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [BIN_WIDTH-1:0]   rd_bin,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic                   rd_last
);

  localparam int NBINS = 1 << BIN_WIDTH;
  localparam logic [BIN_WIDTH-1:0]   c_last_bin  = '1;
  localparam logic [BIN_WIDTH-1:0]   c_bin_one   = {{(BIN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [COUNT_WIDTH-1:0] r_mem [NBINS];
  logic [COUNT_WIDTH-1:0] r_rd_data;
  logic [BIN_WIDTH-1:0]   r_addr;
  logic                   r_to_clear;
  logic                   r_s1_valid;
  logic [BIN_WIDTH-1:0]   r_s1_bin;
  logic                   r_fw_valid;
  logic [BIN_WIDTH-1:0]   r_fw_bin;
  logic [COUNT_WIDTH-1:0] r_fw_data;
  logic                   r_inflight;
  logic                   r_rd_valid;
  logic                   r_rd_last;
  logic [BIN_WIDTH-1:0]   r_rd_bin;
  logic                   r_pix_drop;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_issue;
  logic [COUNT_WIDTH-1:0] w_base;
  logic [COUNT_WIDTH-1:0] w_incr;
  logic                   w_we;
  logic [BIN_WIDTH-1:0]   w_wa;
  logic [COUNT_WIDTH-1:0] w_wd;
  logic                   w_re;
  logic [BIN_WIDTH-1:0]   w_ra;

  assign w_accept = (r_state == ST_ACCUM) && pix_valid;
  // One read per two cycles at most; the final word blocks further issues.
  assign w_issue  = (r_state == ST_READOUT) && !r_inflight &&
                    (!r_rd_valid || rd_ready) && !(r_rd_valid && r_rd_last);

  // The RAM output is stale when the previous cycle wrote the same bin.
  assign w_base = (r_fw_valid && (r_fw_bin == r_s1_bin)) ? r_fw_data : r_rd_data;
  assign w_incr = (SATURATE && (&w_base)) ? w_base : w_base + c_count_one;

  always_comb begin
    w_we = 1'b0;
    w_wa = r_addr;
    w_wd = '0;
    if (r_s1_valid) begin
      w_we = 1'b1;
      w_wa = r_s1_bin;
      w_wd = w_incr;
    end else if ((r_state == ST_CLEAR) || w_issue) begin
      w_we = 1'b1;
    end
  end

  assign w_re = w_accept || w_issue;
  assign w_ra = (r_state == ST_READOUT) ? r_addr : pix_bin;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    if (w_re) r_rd_data <= r_mem[w_ra];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_CLEAR:   if (r_addr == c_last_bin) w_state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (frame_end || clear_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:   w_state_nxt = r_to_clear ? ST_CLEAR : ST_READOUT;
      ST_READOUT: if (r_rd_valid && rd_ready && r_rd_last) w_state_nxt = ST_ACCUM;
      default:    w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_to_clear <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
      r_fw_valid <= 1'b0;
      r_fw_bin   <= '0;
      r_fw_data  <= '0;
      r_inflight <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_bin   <= '0;
      r_pix_drop <= 1'b0;
    end else begin
      r_pix_drop <= pix_valid && !w_in_ready;
      r_s1_valid <= w_accept;
      r_s1_bin   <= pix_bin;
      r_fw_valid <= r_s1_valid;
      r_fw_bin   <= r_s1_bin;
      r_fw_data  <= w_incr;
      r_inflight <= w_issue;
      case (r_state)
        ST_CLEAR:   r_addr <= r_addr + c_bin_one;
        ST_ACCUM: begin
          if (frame_end)      r_to_clear <= 1'b0;
          else if (clear_req) r_to_clear <= 1'b1;
        end
        ST_DRAIN:   r_addr <= '0;
        ST_READOUT: if (w_issue) r_addr <= r_addr + c_bin_one;
        default:    r_addr <= '0;
      endcase
      if (w_issue) begin
        r_rd_valid <= 1'b1;
        r_rd_bin   <= r_addr;
        r_rd_last  <= (r_addr == c_last_bin);
      end else if (r_rd_valid && rd_ready) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  assign in_ready = w_in_ready;
  assign busy     = !w_in_ready;
  assign pix_drop = r_pix_drop;
  assign rd_valid = r_rd_valid;
  assign rd_bin   = r_rd_bin;
  assign rd_count = r_rd_data;
  assign rd_last  = r_rd_last;

endmodule
`default_nettype wire

// File: tb/tb_histogram_accum.sv
`default_nettype none
// tb_histogram_accum: table vectors, hand-written corner sequences and random
// frames checked against an array-of-counters reference model.
module tb_histogram_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pix_valid, frame_end, clear_req, rd_ready;
  logic [7:0]  pix_bin;
  logic        in_ready, pix_drop, busy, rd_valid, rd_last;
  logic [7:0]  rd_bin;
  logic [31:0] rd_count;

  logic        s_pix_valid, s_frame_end, s_clear_req, s_rd_ready;
  logic [2:0]  s_pix_bin;
  logic        sa_in_ready, sa_pix_drop, sa_busy, sa_rd_valid, sa_rd_last;
  logic [2:0]  sa_rd_bin;
  logic [3:0]  sa_rd_count;
  logic        wr_in_ready, wr_pix_drop, wr_busy, wr_rd_valid, wr_rd_last;
  logic [2:0]  wr_rd_bin;
  logic [3:0]  wr_rd_count;

  histogram_accum #(.BIN_WIDTH(8), .COUNT_WIDTH(32), .SATURATE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_bin(pix_bin),
    .frame_end(frame_end), .clear_req(clear_req), .in_ready(in_ready),
    .pix_drop(pix_drop), .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last));

  histogram_accum #(.BIN_WIDTH(3), .COUNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .pix_valid(s_pix_valid), .pix_bin(s_pix_bin),
    .frame_end(s_frame_end), .clear_req(s_clear_req), .in_ready(sa_in_ready),
    .pix_drop(sa_pix_drop), .busy(sa_busy), .rd_valid(sa_rd_valid), .rd_ready(s_rd_ready),
    .rd_bin(sa_rd_bin), .rd_count(sa_rd_count), .rd_last(sa_rd_last));

  histogram_accum #(.BIN_WIDTH(3), .COUNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .pix_valid(s_pix_valid), .pix_bin(s_pix_bin),
    .frame_end(s_frame_end), .clear_req(s_clear_req), .in_ready(wr_in_ready),
    .pix_drop(wr_pix_drop), .busy(wr_busy), .rd_valid(wr_rd_valid), .rd_ready(s_rd_ready),
    .rd_bin(wr_rd_bin), .rd_count(wr_rd_count), .rd_last(wr_rd_last));

  typedef struct packed { logic v; logic [7:0] b; } pix_t;
  typedef struct packed { logic [7:0] bin; logic [31:0] cnt; } hexp_t;
  typedef struct packed { logic [2:0] bin; logic [3:0] sat; logic [3:0] wrp; } sexp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          model [256];
  logic [31:0] got [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_pixels(input int n, input int maxbin);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_bin   = 8'($urandom_range(0, maxbin));
      if (pix_valid && in_ready) model[pix_bin]++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // Counts cycles until in_ready rises; busy must be the exact complement.
  task automatic wait_ready(input int exp_cycles, input string name);
    int k;
    bit busy_bad;
    k = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      k++;
      clear_req = 1'b0;
      if (in_ready == busy) busy_bad = 1'b1;
    end while (!in_ready && k < 1000);
    chk({name, "_delay"}, k, exp_cycles);
    chk({name, "_busy"}, busy_bad, 0);
  endtask

  task automatic compare_model(input string name);
    for (int b = 0; b < 256; b++) begin
      chk($sformatf("%s_bin%0d", name, b), got[b], model[b]);
      model[b] = 0;
    end
  endtask

  task automatic readout(input bit rnd, input bit noise, input bit with_clear,
                         input int abort_at, output bit aborted);
    int idx, cyc, first_v;
    bit stalled, pv_prev, ir_prev;
    logic [40:0] held;
    idx = 0; cyc = 0; first_v = -1; stalled = 1'b0; aborted = 1'b0; held = '0;
    for (int b = 0; b < 256; b++) got[b] = 32'hDEAD_BEEF;
    @(negedge clk);
    frame_end = 1'b1;
    clear_req = with_clear;
    pix_valid = noise;
    pix_bin   = 8'($urandom_range(0, 15));
    if (pix_valid && in_ready) model[pix_bin]++;
    pv_prev  = pix_valid;
    ir_prev  = in_ready;
    rd_ready = 1'b1;
    while (idx < 256) begin
      @(negedge clk);
      cyc++;
      chk("pix_drop", pix_drop, pv_prev && !ir_prev);
      if (cyc == 1) begin
        chk("fe_in_ready", in_ready, 0);
        chk("fe_busy", busy, 1);
      end
      if (cyc == 2) chk("fe_no_early_valid", rd_valid, 0);
      if (stalled) chk("stall_stable", {rd_valid, rd_bin, rd_count, rd_last}, {1'b1, held});
      held      = {rd_bin, rd_count, rd_last};
      frame_end = noise && ($urandom_range(0, 7) == 0);
      clear_req = noise && ($urandom_range(0, 7) == 0);
      pix_valid = noise && ($urandom_range(0, 1) == 1);
      pix_bin   = 8'($urandom_range(0, 255));
      pv_prev   = pix_valid;
      ir_prev   = in_ready;
      rd_ready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      stalled   = rd_valid && !rd_ready;
      if (cyc > 3000) begin
        chk("readout_timeout", idx, 256);
        break;
      end
      if (rd_valid) begin
        if (first_v < 0) first_v = cyc;
        if (abort_at >= 0 && rd_bin == 8'(abort_at)) begin
          rst = 1'b1; pix_valid = 1'b0; frame_end = 1'b0; clear_req = 1'b0;
          aborted = 1'b1;
          break;
        end
        if (rd_ready) begin
          chk("rd_order", rd_bin, idx);
          chk("rd_last", rd_last, idx == 255);
          got[idx] = rd_count;
          if (!rnd && idx == 255) chk("last_word_cycle", cyc, 513);
          idx++;
        end
      end
    end
    if (!rnd) chk("first_valid_cycle", first_v, 3);
    if (!aborted) begin
      @(negedge clk);
      chk("in_ready_after_last", in_ready, 1);
      frame_end = 1'b0; clear_req = 1'b0; pix_valid = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_t  pix_tab [12];
    hexp_t hz_tab  [7];
    sexp_t s_tab   [8];
    logic [3:0] sa_got [8];
    logic [3:0] wr_got [8];
    int sa_n, wr_n;
    bit ab;

    pix_tab = '{'{1'b1, 8'd5}, '{1'b1, 8'd5}, '{1'b1, 8'd5}, '{1'b1, 8'd7},
                '{1'b1, 8'd5}, '{1'b0, 8'd0}, '{1'b1, 8'd9}, '{1'b0, 8'd9},
                '{1'b1, 8'd9}, '{1'b1, 8'd9}, '{1'b1, 8'd200}, '{1'b1, 8'd200}};
    hz_tab  = '{'{8'd5, 32'd4}, '{8'd7, 32'd1}, '{8'd9, 32'd3}, '{8'd200, 32'd2},
                '{8'd0, 32'd0}, '{8'd6, 32'd0}, '{8'd255, 32'd0}};
    s_tab   = '{'{3'd0, 4'd0, 4'd0}, '{3'd1, 4'd0, 4'd0}, '{3'd2, 4'd0, 4'd0},
                '{3'd3, 4'd15, 4'd4}, '{3'd4, 4'd0, 4'd0}, '{3'd5, 4'd0, 4'd0},
                '{3'd6, 4'd5, 4'd5}, '{3'd7, 4'd0, 4'd0}};
    for (int b = 0; b < 256; b++) model[b] = 0;

    rst = 1'b1; pix_valid = 1'b0; pix_bin = '0; frame_end = 1'b0; clear_req = 1'b0;
    rd_ready = 1'b0;
    s_pix_valid = 1'b0; s_pix_bin = '0; s_frame_end = 1'b0; s_clear_req = 1'b0;
    s_rd_ready = 1'b1;

    @(negedge clk);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_last", rd_last, 0);
    chk("reset_pix_drop", pix_drop, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(256, "reset_sweep");

    readout(1'b0, 1'b0, 1'b0, -1, ab);
    compare_model("idle");

    // Saturating vs wrapping 4-bit counters, same stimulus.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_pix_valid = 1'b1; s_pix_bin = 3'd3;
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_pix_valid = (i != 1 && i != 4); s_pix_bin = 3'd6;
    end
    @(negedge clk);
    s_pix_valid = 1'b0; s_frame_end = 1'b1;
    @(negedge clk);
    s_frame_end = 1'b0;
    sa_n = 0; wr_n = 0;
    for (int c = 0; c < 60 && (sa_n < 8 || wr_n < 8); c++) begin
      @(negedge clk);
      if (sa_rd_valid) begin
        chk("sat_order", sa_rd_bin, sa_n);
        chk("sat_last", sa_rd_last, sa_n == 7);
        sa_got[sa_rd_bin] = sa_rd_count;
        sa_n++;
      end
      if (wr_rd_valid) begin
        chk("wrap_order", wr_rd_bin, wr_n);
        chk("wrap_last", wr_rd_last, wr_n == 7);
        wr_got[wr_rd_bin] = wr_rd_count;
        wr_n++;
      end
    end
    chk("sat_words", sa_n, 8);
    chk("wrap_words", wr_n, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sat_bin%0d", s_tab[i].bin), sa_got[s_tab[i].bin], s_tab[i].sat);
      chk($sformatf("wrap_bin%0d", s_tab[i].bin), wr_got[s_tab[i].bin], s_tab[i].wrp);
    end

    // Same-bin hazards: back-to-back, interleaved and one-gap sequences.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pix_valid = pix_tab[i].v;
      pix_bin   = pix_tab[i].b;
      if (pix_valid && in_ready) model[pix_bin]++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    readout(1'b0, 1'b0, 1'b0, -1, ab);
    for (int i = 0; i < 7; i++)
      chk($sformatf("hazard_bin%0d", hz_tab[i].bin), got[hz_tab[i].bin], hz_tab[i].cnt);
    compare_model("hazard");

    for (int r = 0; r < 3; r++) begin
      drive_pixels(500, (r == 0) ? 7 : 255);
      readout(1'b1, 1'b1, r == 1, -1, ab);
      compare_model($sformatf("rand%0d", r));
      readout(1'b1, 1'b0, 1'b0, -1, ab);
      compare_model($sformatf("rand%0d_second", r));
    end

    drive_pixels(200, 31);
    @(negedge clk);
    clear_req = 1'b1;
    wait_ready(258, "clear_req_sweep");
    for (int b = 0; b < 256; b++) model[b] = 0;
    readout(1'b1, 1'b1, 1'b0, -1, ab);
    compare_model("after_clear");

    drive_pixels(300, 255);
    readout(1'b0, 1'b0, 1'b0, 100, ab);
    chk("abort_reached", ab, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_busy", busy, 1);
    wait_ready(256, "abort_sweep");
    for (int b = 0; b < 256; b++) model[b] = 0;
    readout(1'b1, 1'b0, 1'b0, -1, ab);
    compare_model("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
